// File: rtl/cw_sel_pkg.sv
// Shared types and helpers for the per-beam codeword selector.
package cw_sel_pkg;

   localparam int ANTS_DEF    = 32;
   localparam int WIDTH_DEF   = 32;
   localparam int BEAM_DEF    = 16;
   localparam int PHASES_DEF  = 4;
   localparam int IDXW_DEF    = 8;
   localparam int ROM_LAT_DEF = 4;

   // One antenna-array codeword at the default geometry.
   typedef logic [WIDTH_DEF*ANTS_DEF-1:0] cw_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      READY = 2'd3
   } load_state_e;

   // Number of symbol-index bits that carry the phase (at least one bit so
   // that slices stay legal when there is a single phase).
   function automatic int phase_bits(input int phases);
      return (phases > 1) ? $clog2(phases) : 1;
   endfunction

   // Table depth: one entry per beam per phase.
   function automatic int depth_of(input int beam, input int phases);
      return beam * phases;
   endfunction

endpackage

// File: rtl/cw_table_loader.sv
// Streams the codeword table out of the ROM and tags returning data with the
// address it belongs to, delayed by the ROM read latency.
//
// state | meaning
// IDLE  | no table loaded since reset
// READ  | issuing one ROM read per cycle, addresses 0..DEPTH-1
// DRAIN | waiting for the last ROM_LAT reads to come back
// READY | table complete, selection allowed
module cw_table_loader
   import cw_sel_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int ROM_LAT = 4,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_load_start,
   output logic          o_busy,
   output logic          o_tvalid,
   output logic          o_rom_rden,
   output logic [AW-1:0] o_rom_addr,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr
);

   localparam int CNTW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   load_state_e     state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            tag_vld_q  [ROM_LAT];
   logic            tag_vld_d  [ROM_LAT];
   logic [AW-1:0]   tag_addr_q [ROM_LAT];
   logic [AW-1:0]   tag_addr_d [ROM_LAT];

   // Next-state, address counter and drain down-counter.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, READY: begin
            if (i_load_start) begin
               state_d = READ;
               addr_d  = '0;
            end
         end
         READ: begin
            if (addr_q == AW'(DEPTH - 1)) begin
               state_d = DRAIN;
               addr_d  = '0;
               cnt_d   = CNTW'(ROM_LAT - 1);
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Delay line that pairs each ROM read with the data returning ROM_LAT later.
   always_comb begin
      tag_vld_d[0]  = (state_q == READ);
      tag_addr_d[0] = addr_q;
      for (int k = 1; k < ROM_LAT; k++) begin
         tag_vld_d[k]  = tag_vld_q[k-1];
         tag_addr_d[k] = tag_addr_q[k-1];
      end
   end

   // State, counters and tag registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < ROM_LAT; k++) begin
            tag_vld_q[k]  <= 1'b0;
            tag_addr_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         tag_vld_q  <= tag_vld_d;
         tag_addr_q <= tag_addr_d;
      end
   end

   assign o_busy     = (state_q == READ) || (state_q == DRAIN);
   assign o_tvalid   = (state_q == READY);
   assign o_rom_rden = (state_q == READ);
   assign o_rom_addr = addr_q;
   assign o_wr_en    = tag_vld_q[ROM_LAT-1];
   assign o_wr_addr  = tag_addr_q[ROM_LAT-1];

endmodule

// File: rtl/codeword_sel_gen.sv
// Per-beam even/odd codeword selector: holds the codeword map loaded from ROM
// and registers one codeword pair per beam, chosen by phase or beam index.
module codeword_sel_gen
   import cw_sel_pkg::*;
#(
   parameter int ANTS    = ANTS_DEF,
   parameter int BEAM    = BEAM_DEF,
   parameter int WIDTH   = WIDTH_DEF,
   parameter int PHASES  = PHASES_DEF,
   parameter int IDXW    = IDXW_DEF,
   parameter int ROM_LAT = ROM_LAT_DEF,
   localparam int DEPTH  = depth_of(BEAM, PHASES),
   localparam int AW     = $clog2(DEPTH),
   localparam int CWW    = WIDTH * ANTS,
   localparam int PHW    = phase_bits(PHASES)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load_start,
   output logic                  o_busy,
   output logic                  o_tvalid,
   output logic                  o_rom_rden,
   output logic [AW-1:0]         o_rom_addr,
   input  logic [CWW-1:0]        i_rom_even,
   input  logic [CWW-1:0]        i_rom_odd,
   input  logic                  i_symb_clr,
   input  logic                  i_symb_1st,
   input  logic [7:0]            i_symb_idx,
   input  logic                  i_rbg_load,
   input  logic [BEAM*IDXW-1:0]  i_beam_idx,
   output logic [BEAM*CWW-1:0]   o_cw_even,
   output logic [BEAM*CWW-1:0]   o_cw_odd,
   output logic [BEAM-1:0]       o_idx_err
);

   logic          wr_en;
   logic [AW-1:0] wr_addr;

   logic [CWW-1:0]  map_even_q [DEPTH];
   logic [CWW-1:0]  map_even_d [DEPTH];
   logic [CWW-1:0]  map_odd_q  [DEPTH];
   logic [CWW-1:0]  map_odd_d  [DEPTH];
   logic [CWW-1:0]  cw_even_q  [BEAM];
   logic [CWW-1:0]  cw_even_d  [BEAM];
   logic [CWW-1:0]  cw_odd_q   [BEAM];
   logic [CWW-1:0]  cw_odd_d   [BEAM];
   logic [BEAM-1:0] idx_err_q, idx_err_d;

   int              phase;
   int              sel;
   logic [IDXW-1:0] bidx;
   logic            unused_symb_bits;

   cw_table_loader #(
      .DEPTH   (DEPTH),
      .ROM_LAT (ROM_LAT),
      .AW      (AW)
   ) u_loader (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load_start (i_load_start),
      .o_busy       (o_busy),
      .o_tvalid     (o_tvalid),
      .o_rom_rden   (o_rom_rden),
      .o_rom_addr   (o_rom_addr),
      .o_wr_en      (wr_en),
      .o_wr_addr    (wr_addr)
   );

   // Only the low phase bits of the symbol index matter.
   assign unused_symb_bits = ^i_symb_idx;

   // Map write from the latency-tagged ROM return.
   always_comb begin
      map_even_d = map_even_q;
      map_odd_d  = map_odd_q;
      if (wr_en) begin
         map_even_d[wr_addr] = i_rom_even;
         map_odd_d[wr_addr]  = i_rom_odd;
      end
   end

   // Per-beam selection: clr over 1st over rbg_load, gated by a valid table.
   always_comb begin
      cw_even_d = cw_even_q;
      cw_odd_d  = cw_odd_q;
      idx_err_d = '0;
      phase     = (PHASES > 1) ? int'(i_symb_idx[PHW-1:0]) : 0;
      sel       = 0;
      bidx      = '0;
      for (int i = 0; i < BEAM; i++) begin
         sel  = -1;
         bidx = i_beam_idx[i*IDXW +: IDXW];
         if (o_tvalid) begin
            if (i_symb_clr) begin
               sel = i;
            end else if (i_symb_1st) begin
               sel = i + BEAM * phase;
            end else if (i_rbg_load) begin
               if (int'(bidx) >= DEPTH) begin
                  idx_err_d[i] = 1'b1;
               end else begin
                  sel = int'(bidx);
               end
            end
         end
         if (sel >= 0) begin
            cw_even_d[i] = map_even_q[AW'(sel)];
            cw_odd_d[i]  = map_odd_q[AW'(sel)];
         end
      end
   end

   // Map, selection and error registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            map_even_q[k] <= '0;
            map_odd_q[k]  <= '0;
         end
         for (int i = 0; i < BEAM; i++) begin
            cw_even_q[i] <= '0;
            cw_odd_q[i]  <= '0;
         end
         idx_err_q <= '0;
      end else begin
         map_even_q <= map_even_d;
         map_odd_q  <= map_odd_d;
         cw_even_q  <= cw_even_d;
         cw_odd_q   <= cw_odd_d;
         idx_err_q  <= idx_err_d;
      end
   end

   // Pack per-beam registers onto the flat output buses.
   always_comb begin
      o_cw_even = '0;
      o_cw_odd  = '0;
      for (int i = 0; i < BEAM; i++) begin
         o_cw_even[i*CWW +: CWW] = cw_even_q[i];
         o_cw_odd[i*CWW +: CWW]  = cw_odd_q[i];
      end
   end

   assign o_idx_err = idx_err_q;

endmodule

// File: tb/tb_codeword_sel_gen.sv
// Directed bench for codeword_sel_gen at the default geometry
// (16 beams, 4 phases, 64-entry table, ROM latency 4).
module tb_codeword_sel_gen;
   import cw_sel_pkg::*;

   localparam int BEAM  = 16;
   localparam int DEPTH = 64;
   localparam int LAT   = 4;
   localparam int CWW   = 1024;
   localparam int ANTS  = 32;

   logic              clk;
   logic              rst;
   logic              load_start;
   logic              busy, tvalid, rden;
   logic [5:0]        rom_addr;
   logic [CWW-1:0]    rom_even, rom_odd;
   logic              symb_clr, symb_1st, rbg_load;
   logic [7:0]        symb_idx;
   logic [127:0]      beam_idx;
   logic [BEAM*CWW-1:0] cw_even, cw_odd;
   logic [15:0]       idx_err;

   int total = 0;
   int bad   = 0;
   int seed  = 0;

   cw_t  exp_e [BEAM];
   cw_t  exp_o [BEAM];
   logic [5:0] rp [LAT];

   codeword_sel_gen dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_load_start (load_start),
      .o_busy       (busy),
      .o_tvalid     (tvalid),
      .o_rom_rden   (rden),
      .o_rom_addr   (rom_addr),
      .i_rom_even   (rom_even),
      .i_rom_odd    (rom_odd),
      .i_symb_clr   (symb_clr),
      .i_symb_1st   (symb_1st),
      .i_symb_idx   (symb_idx),
      .i_rbg_load   (rbg_load),
      .i_beam_idx   (beam_idx),
      .o_cw_even    (cw_even),
      .o_cw_odd     (cw_odd),
      .o_idx_err    (idx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic cw_t pat_e(input int k, input int s);
      cw_t v;
      logic [31:0] sv;
      sv = s;
      for (int j = 0; j < ANTS; j++)
         v[j*32 +: 32] = {8'hA5 ^ sv[7:0], 8'(k), 8'(j), 8'(k + s)};
      return v;
   endfunction

   function automatic cw_t pat_o(input int k, input int s);
      cw_t v;
      for (int j = 0; j < ANTS; j++)
         v[j*32 +: 32] = {8'h5A, 8'(j), 8'(k), 8'(~k ^ s)};
      return v;
   endfunction

   // External ROM model with a ROM_LAT-cycle read pipeline.
   always @(posedge clk) begin
      rp[0] <= rom_addr;
      for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
   end
   assign rom_even = pat_e(int'(rp[LAT-1]), seed);
   assign rom_odd  = pat_o(int'(rp[LAT-1]), seed);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   task automatic check_all(input string nm);
      int badb;
      badb = -1;
      for (int i = 0; i < BEAM; i++)
         if (badb < 0 && (cw_even[i*CWW +: CWW] !== exp_e[i] || cw_odd[i*CWW +: CWW] !== exp_o[i]))
            badb = i;
      total++;
      if (badb >= 0) begin
         bad++;
         $display("FAIL %s: beam %0d even[31:0] got %h want %h odd[31:0] got %h want %h", nm, badb,
                  cw_even[badb*CWW +: 32], exp_e[badb][31:0], cw_odd[badb*CWW +: 32], exp_o[badb][31:0]);
      end
   endtask

   task automatic model_sel(input logic clr, input logic first, input logic rbg,
                            input logic [7:0] symb, input logic [127:0] bidx);
      for (int i = 0; i < BEAM; i++) begin
         int s;
         s = -1;
         if (clr) s = i;
         else if (first) s = i + BEAM * int'(symb[1:0]);
         else if (rbg && bidx[i*8 +: 8] < 8'd64) s = int'(bidx[i*8 +: 8]);
         if (s >= 0) begin
            exp_e[i] = pat_e(s, seed);
            exp_o[i] = pat_o(s, seed);
         end
      end
   endtask

   task automatic model_zero();
      for (int i = 0; i < BEAM; i++) begin
         exp_e[i] = '0;
         exp_o[i] = '0;
      end
   endtask

   task automatic idle_inputs();
      symb_clr = 0; symb_1st = 0; rbg_load = 0; symb_idx = 0; beam_idx = '0;
   endtask

   // Full load; optional second start at cycle second_at and gated selection
   // requests held for the whole load when reqs is set.
   task automatic do_load(input string nm, input int second_at, input bit reqs);
      int n, seq_bad, err_bad;
      bit risen;
      n = 0; seq_bad = 0; err_bad = 0; risen = 0;
      @(negedge clk);
      load_start = 1;
      while (n < 200 && !risen) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) load_start = 0;
         if (n == second_at) load_start = 1;
         if (n == second_at + 1) load_start = 0;
         if (reqs && n == 1) begin
            symb_1st = 1; symb_idx = 8'd3; rbg_load = 1; beam_idx = {16{8'd200}};
         end
         if (n <= 64) begin
            if (rden !== 1'b1 || rom_addr !== 6'(n - 1)) seq_bad++;
         end else if (rden !== 1'b0) seq_bad++;
         if (busy !== (n <= 68)) seq_bad++;
         if (idx_err !== 16'h0) err_bad++;
         risen = (tvalid === 1'b1);
         if (risen) idle_inputs();
      end
      chk({nm, "_cycles"}, n, 69);
      chk({nm, "_rom_seq"}, seq_bad, 0);
      if (reqs) begin
         chk({nm, "_err_gated"}, err_bad, 0);
         check_all({nm, "_cw_held"});
      end
   endtask

   typedef struct {
      logic         clr;
      logic         first;
      logic         rbg;
      logic [7:0]   symb;
      logic [127:0] bidx;
      logic [15:0]  err;
      int           hb;
      int           hidx;
   } vec_t;

   vec_t vt [10];

   initial begin
      logic [127:0] b5, b7, b8;
      int n;
      for (int i = 0; i < BEAM; i++) begin
         b5[i*8 +: 8] = 8'(63 - i);
         b7[i*8 +: 8] = 8'(4 * i + 3);
      end
      b5[7:0] = 8'd5; b5[15:8] = 8'd200;
      b8 = b7; b8[127:120] = 8'd64; b8[119:112] = 8'd255;

      vt[0] = '{0, 1, 0, 8'd6, '0, 16'h0000, 15, 47};
      vt[1] = '{0, 1, 0, 8'd1, '0, 16'h0000,  0, 16};
      vt[2] = '{0, 1, 0, 8'd3, '0, 16'h0000, 15, 63};
      vt[3] = '{1, 1, 0, 8'd7, '0, 16'h0000,  7,  7};
      vt[4] = '{0, 1, 0, 8'd5, '0, 16'h0000,  2, 18};
      vt[5] = '{0, 0, 1, 8'd0, b5, 16'h0002,  1, 17};
      vt[6] = '{0, 0, 0, 8'd0, '0, 16'h0000,  1, 17};
      vt[7] = '{0, 0, 1, 8'd0, b7, 16'h0000,  0,  3};
      vt[8] = '{0, 0, 1, 8'd0, b8, 16'hC000, 15, 63};
      vt[9] = '{1, 0, 1, 8'd0, {16{8'd255}}, 16'h0000, 9, 9};

      rst = 1; load_start = 0; idle_inputs(); model_zero();
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rden", rden, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_err", idx_err, 0);
      check_all("rst_cw");

      // Requests before any table is loaded are ignored.
      @(negedge clk);
      symb_clr = 1; rbg_load = 1; beam_idx = {16{8'd200}};
      @(posedge clk); #1;
      check_all("idle_cw_held");
      chk("idle_err", idx_err, 0);
      idle_inputs();

      seed = 0;
      do_load("load1", 0, 0);
      chk("load1_tvalid", tvalid, 1);

      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         symb_clr = vt[v].clr; symb_1st = vt[v].first; rbg_load = vt[v].rbg;
         symb_idx = vt[v].symb; beam_idx = vt[v].bidx;
         @(posedge clk); #1;
         model_sel(vt[v].clr, vt[v].first, vt[v].rbg, vt[v].symb, vt[v].bidx);
         check_all($sformatf("vec%0d_cw", v));
         chk($sformatf("vec%0d_err", v), idx_err, vt[v].err);
         total++;
         if (cw_even[vt[v].hb*CWW +: CWW] !== pat_e(vt[v].hidx, seed) ||
             cw_odd[vt[v].hb*CWW +: CWW]  !== pat_o(vt[v].hidx, seed)) begin
            bad++;
            $display("FAIL vec%0d_hand: beam %0d even[31:0] got %h want %h", v, vt[v].hb,
                     cw_even[vt[v].hb*CWW +: 32], pat_e(vt[v].hidx, seed) & 32'hFFFF_FFFF);
         end
      end
      @(negedge clk); idle_inputs();
      @(posedge clk); #1;
      chk("err_pulse_end", idx_err, 0);

      // Reload with a new table while requests are held; second start ignored.
      seed = 1;
      do_load("reload", 10, 1);
      @(negedge clk); symb_clr = 1;
      @(posedge clk); #1;
      model_sel(1, 0, 0, 8'd0, '0);
      check_all("reload_clr");
      @(negedge clk); idle_inputs();

      // Reset in the middle of a load.
      seed = 2;
      @(negedge clk); load_start = 1;
      n = 0;
      while (n < 100 && rom_addr !== 6'd30) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) load_start = 0;
      end
      chk("mid_addr30_cycle", n, 31);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      model_zero();
      chk("midrst_rden", rden, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_tvalid", tvalid, 0);
      chk("midrst_addr", rom_addr, 0);
      check_all("midrst_cw");
      do_load("fresh", 0, 0);
      @(negedge clk); symb_1st = 1; symb_idx = 8'd2;
      @(posedge clk); #1;
      model_sel(0, 1, 0, 8'd2, '0);
      check_all("fresh_phase2");
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
